// File: rtl/inv_key_scheduler.sv
// Inverse key scheduler: buffers forward round-key triples, then replays them
// last round first with words swapped. Optional parity: `INV_KEY_PARITY_EN.
module inv_key_scheduler #(
  parameter int KEY_W  = 8,
  parameter int ROUNDS = 8,
  parameter int RND_W  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             k_valid,
  input  logic [KEY_W-1:0] K_1,
  input  logic [KEY_W-1:0] K_2,
  input  logic [KEY_W-1:0] K_3,
  output logic             k_ready,
  output logic             dk_valid,
  input  logic             dk_ready,
  output logic [KEY_W-1:0] DK_1,
  output logic [KEY_W-1:0] DK_2,
  output logic [KEY_W-1:0] DK_3,
  output logic [RND_W-1:0] rnd,
  output logic             busy,
  output logic             done
`ifdef INV_KEY_PARITY_EN
  ,
  input  logic             k_par,
  output logic             dk_par,
  output logic             par_err
`endif
);

  localparam int PTR_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int WRD_W = 3 * KEY_W;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ROUNDS - 1);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_REPLAY,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             dkv_q, dkv_d;
  logic [KEY_W-1:0] dk1_q, dk1_d;
  logic [KEY_W-1:0] dk2_q, dk2_d;
  logic [KEY_W-1:0] dk3_q, dk3_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             done_q, done_d;
  logic             wr_en;
  logic [WRD_W-1:0] rd_word;

  // Triple store: {K_1,K_2,K_3}, K_3 in the low word
  logic [WRD_W-1:0] mem_q [ROUNDS];

  assign rd_word = mem_q[rd_ptr_q];

`ifdef INV_KEY_PARITY_EN
  logic dkp_q, dkp_d;
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dkv_d    = dkv_q;
    dk1_d    = dk1_q;
    dk2_d    = dk2_q;
    dk3_d    = dk3_q;
    rnd_d    = rnd_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
`ifdef INV_KEY_PARITY_EN
    dkp_d    = dkp_q;
    perr_d   = perr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d  = S_LOAD;
          wr_ptr_d = ZERO;
`ifdef INV_KEY_PARITY_EN
          perr_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (k_valid) begin
          wr_en = 1'b1;
`ifdef INV_KEY_PARITY_EN
          if ((^{K_1, K_2, K_3}) != k_par)
            perr_d = 1'b1;
`endif
          if (wr_ptr_q == LAST) begin
            state_d  = S_FETCH;
            rd_ptr_d = LAST;
          end else begin
            wr_ptr_d = wr_ptr_q + ONE;
          end
        end
      end
      S_FETCH: begin
        if (!en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REPLAY;
          dkv_d   = 1'b1;
          dk1_d   = rd_word[KEY_W-1:0];
          dk2_d   = rd_word[2*KEY_W-1:KEY_W];
          dk3_d   = rd_word[WRD_W-1:2*KEY_W];
          rnd_d   = RND_W'(rd_ptr_q);
`ifdef INV_KEY_PARITY_EN
          dkp_d   = ^rd_word;
`endif
        end
      end
      S_REPLAY: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (dkv_q && dk_ready) begin
          dkv_d = 1'b0;
          if (rd_ptr_q == ZERO) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = S_FETCH;
            rd_ptr_d = rd_ptr_q - ONE;
          end
        end
      end
      S_DONE: begin
        if (!en)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort and normal exit both land here with clean pointers
    if (state_d == S_IDLE) begin
      wr_ptr_d = ZERO;
      rd_ptr_d = ZERO;
      dkv_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dkv_q    <= 1'b0;
      dk1_q    <= '0;
      dk2_q    <= '0;
      dk3_q    <= '0;
      rnd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dkv_q    <= dkv_d;
      dk1_q    <= dk1_d;
      dk2_q    <= dk2_d;
      dk3_q    <= dk3_d;
      rnd_q    <= rnd_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_en)
      mem_q[wr_ptr_q] <= {K_1, K_2, K_3};
  end

`ifdef INV_KEY_PARITY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      dkp_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      dkp_q  <= dkp_d;
      perr_q <= perr_d;
    end
  end

  assign dk_par  = dkp_q;
  assign par_err = perr_q;
`endif

  assign k_ready  = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD) ||
                    (state_q == S_FETCH) ||
                    (state_q == S_REPLAY);
  assign dk_valid = dkv_q;
  assign DK_1     = dk1_q;
  assign DK_2     = dk2_q;
  assign DK_3     = dk3_q;
  assign rnd      = rnd_q;
  assign done     = done_q;

endmodule
